kim_skid_buffer: RTL and testbench
==================================

# kim_skid_buffer

Two-entry, fully registered skid buffer that sits directly upstream of `kim_FIFO_wrapper` and drives its `s_valid/s_ready/s_data` port. It breaks the combinational ready path between the producer and the FIFO: `s_ready`, `m_valid` and `m_data` all come straight from flops. It sustains one transfer per cycle with one cycle of latency. A synchronous `flush` discards buffered contents.

## Interface
- `FIFO_DATA_LENGTH`, 32: payload width in bits; must match the downstream FIFO.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of both entries.
- `s_valid`  in  1  producer data valid.
- `s_ready`  out  1  buffer can accept; registered.
- `s_data`  in  FIFO_DATA_LENGTH  producer payload.
- `m_valid`  out  1  output entry valid; registered; connects to FIFO `s_valid`.
- `m_ready`  in  1  FIFO ready (FIFO `s_ready`).
- `m_data`  out  FIFO_DATA_LENGTH  output entry payload; registered.
- `occupancy`  out  2  number of held entries, 0..2.

## Operation
- Handshakes:
  - `s_hs = s_valid & s_ready`.
  - `m_hs = m_valid & m_ready`.
- Storage:
  - Output register `out_q` drives `m_data`.
  - Skid register `skid_q` holds at most one word.
- States:
  - EMPTY (occupancy 0).
  - BUSY (occupancy 1, in `out_q`).
  - FULL (occupancy 2, `out_q` plus `skid_q`).
- Transitions:
  - EMPTY: on `s_hs`, `out_q<=s_data` and go to BUSY; otherwise stay.
  - BUSY, `s_hs & !m_hs`: `skid_q<=s_data`, go to FULL.
  - BUSY, `!s_hs & m_hs`: go to EMPTY.
  - BUSY, `s_hs & m_hs`: `out_q<=s_data`, stay in BUSY.
  - BUSY, neither handshake: hold.
  - FULL, `m_hs`: `out_q<=skid_q`, go to BUSY. `s_hs` is impossible here because `s_ready=0`.
  - FULL, no `m_hs`: hold.
- Registered outputs:
  - `s_ready` <= (next state != FULL).
  - `m_valid` <= (next state != EMPTY).
  - `occupancy` tracks the state.
- Flush:
  - Next state is EMPTY regardless of handshakes.
  - A word accepted via `s_hs` in the flush cycle is dropped.
  - A word taken by `m_hs` in the flush cycle is a valid transfer.
  - Next cycle: `m_valid=0`, `s_ready=1`, `occupancy=0`.
- Ordering: words leave in acceptance order. No duplication and no loss, except for flush.
- AXI-style rules:
  - Once `m_valid` is asserted, `m_valid` and `m_data` hold until `m_hs`.
  - `m_valid` never depends combinationally on `m_ready`.

## Timing
- Reset (rst=0), applied asynchronously and independent of `clk`:
  - `s_ready=0`, `m_valid=0`, `m_data=0`, `occupancy=0`, `skid_q=0`, state EMPTY.
- `s_ready` rises on the first `clk` edge after `rst` deasserts.
- Latency: `s_hs` at edge N gives `m_valid=1` with that word after edge N.
- Throughput: 1 word/cycle while `m_ready=1`.
- Backpressure:
  - `m_ready` low in BUSY with `s_valid` high gives FULL after one edge.
  - `s_ready` drops one cycle after the word that filled the skid entry.
  - `s_ready` recovers one edge after the `m_hs` that leaves FULL.
- Reset mid-operation: both entries are discarded immediately. Downstream sees `m_valid` fall asynchronously.
- Flush with `rst`: `rst` dominates.

## Structure
- Shared package `kim_fifo_pkg` holds:
  - The 2-bit state encoding: EMPTY=2'd0, BUSY=2'd1, FULL=2'd2.
  - The default `FIFO_DATA_LENGTH` constant, also used by `kim_FIFO_wrapper`.
- No sub-module: a single flat module with one state register, two data registers and registered flags.
- Integration: a top level instantiates `kim_skid_buffer` feeding `kim_FIFO_wrapper`, with `m_*` connected to the FIFO's `s_*`.

## Test plan
- **Reset:** hold `rst=0` for 3 edges with `s_valid=1`.
  - During reset: `s_ready=0`, `m_valid=0`, `m_data=0`, `occupancy=0`.
  - One edge after release: `s_ready=1`, `m_valid=0`.
- **Streaming:** `m_ready=1` constant; send 0x1..0x8 on consecutive cycles.
  - `m_data` shows 0x1..0x8 on consecutive cycles, each one cycle after acceptance.
  - `occupancy` stays 1; `s_ready` never drops.
- **Stall and skid:** `m_ready=0`; send 0xA then 0xB.
  - `occupancy` goes to 2; `s_ready=0`; `m_data=0xA` holds stably.
  - Raise `m_ready`: output is 0xA, then 0xB.
  - `s_ready` returns to 1 one edge after 0xA leaves.
- **Simultaneous handshake:** in BUSY holding 0x5, `s_hs` with 0x6 and `m_hs` in the same cycle.
  - Next cycle: `m_data=0x6`, `occupancy=1`, `s_ready=1`.
- **Flush:** in FULL holding 0xC/0xD, pulse `flush` with `m_ready=0`.
  - Next cycle: `m_valid=0`, `occupancy=0`, `s_ready=1`.
  - Then send 0xE: it emerges with no trace of 0xC/0xD.
- **Random soak:** 10k cycles of random `s_valid`/`m_ready` against a scoreboard.
  - No loss, reordering or duplication.
  - `m_data` stable while stalled; `occupancy` always matches the model.

Source files
------------

// File: rtl/kim_fifo_pkg.sv
// -----------------------------------------------------------------------------
// kim_fifo_pkg
// Shared definitions for the kim FIFO datapath: the default payload width
// (common to kim_skid_buffer and kim_FIFO_wrapper) and the 2-bit skid buffer
// state encoding. The encoding is chosen so that the state value equals the
// number of held entries, which lets the occupancy output mirror the state.
// -----------------------------------------------------------------------------
package kim_fifo_pkg;

  localparam int FIFO_DATA_LENGTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // no entries held
    ST_BUSY  = 2'd1,  // one entry, in the output register
    ST_FULL  = 2'd2   // two entries, output register plus skid register
  } skid_state_t;

endpackage : kim_fifo_pkg

// File: rtl/kim_skid_buffer.sv
// -----------------------------------------------------------------------------
// kim_skid_buffer
// Two-entry, fully registered skid buffer placed in front of kim_FIFO_wrapper.
// Breaks the combinational ready path: s_ready, m_valid, m_data and occupancy
// all come straight from flops. One transfer per cycle, one cycle latency.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   flush      synchronous clear of both entries
//   s_valid    producer data valid
//   s_ready    buffer can accept (registered)
//   s_data     producer payload
//   m_valid    output entry valid (registered), to FIFO s_valid
//   m_ready    FIFO ready (FIFO s_ready)
//   m_data     output entry payload (registered)
//   occupancy  number of held entries, 0..2 (equals the state encoding)
//
// Handshake: a word moves on a rising edge when valid and ready are both high
// on that interface; valid, once high, holds with stable data until it is
// taken, and valid never depends combinationally on ready.
// -----------------------------------------------------------------------------
module kim_skid_buffer
  import kim_fifo_pkg::*;
#(
  parameter int FIFO_DATA_LENGTH = FIFO_DATA_LENGTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [FIFO_DATA_LENGTH-1:0] s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [FIFO_DATA_LENGTH-1:0] m_data,
  output logic [1:0]                  occupancy
);

  skid_state_t                 state_q;
  skid_state_t                 next_state;
  logic [FIFO_DATA_LENGTH-1:0] out_q;
  logic [FIFO_DATA_LENGTH-1:0] out_d;
  logic [FIFO_DATA_LENGTH-1:0] skid_q;
  logic [FIFO_DATA_LENGTH-1:0] skid_d;
  logic                        s_ready_q;
  logic                        m_valid_q;
  logic [1:0]                  occ_q;

  logic s_hs;
  logic m_hs;

  // Handshakes use the registered flags, so nothing here feeds back
  // combinationally from m_ready to m_valid or from s_valid to s_ready.
  assign s_hs = s_valid & s_ready_q;
  assign m_hs = m_valid_q & m_ready;

  always_comb begin
    next_state = state_q;
    out_d      = out_q;
    skid_d     = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (s_hs) begin
          out_d      = s_data;
          next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (s_hs && !m_hs) begin
          skid_d     = s_data;
          next_state = ST_FULL;
        end else if (!s_hs && m_hs) begin
          next_state = ST_EMPTY;
        end else if (s_hs && m_hs) begin
          out_d = s_data;
        end
      end
      ST_FULL: begin
        // s_ready is low in FULL, so only the drain side can move.
        if (m_hs) begin
          out_d      = skid_q;
          next_state = ST_BUSY;
        end
      end
      default: next_state = ST_EMPTY;
    endcase
    // Flush overrides everything: a word taken by m_hs this cycle still
    // counts as delivered, a word accepted by s_hs this cycle is dropped.
    if (flush) begin
      next_state = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_EMPTY;
      out_q     <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      state_q   <= next_state;
      out_q     <= out_d;
      skid_q    <= skid_d;
      // Flags are precomputed from the next state so they leave a flop.
      s_ready_q <= (next_state != ST_FULL);
      m_valid_q <= (next_state != ST_EMPTY);
      occ_q     <= next_state;
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = out_q;
  assign occupancy = occ_q;

endmodule : kim_skid_buffer

// File: tb/tb_kim_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_kim_skid_buffer
// Directed steps followed by a random soak. The reference is a queue of held
// words: outputs are derived from its contents (front word, size) rather than
// from any state machine.
// -----------------------------------------------------------------------------
module tb_kim_skid_buffer;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic [1:0]   occupancy;

  int total = 0;
  int bad   = 0;

  // Reference: words held by the buffer, front = next to leave.
  logic [W-1:0] exp_q[$];
  bit           started;   // s_ready comes up one edge after reset release
  int           delivered;

  kim_skid_buffer #(.FIFO_DATA_LENGTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_s_ready();
    return started && (exp_q.size() < 2);
  endfunction

  // Compare every output with the queue model.
  task automatic check_model(input string tag);
    chk({tag, "_s_ready"}, W'(s_ready), W'(exp_s_ready()));
    chk({tag, "_m_valid"}, W'(m_valid), W'(exp_q.size() != 0));
    chk({tag, "_occ"}, W'(occupancy), W'(exp_q.size()));
    if (exp_q.size() != 0) chk({tag, "_m_data"}, m_data, exp_q[0]);
  endtask

  // Driver: apply inputs, take one rising edge, update the model, check.
  task automatic step(input logic sv, input logic [W-1:0] sd, input logic mr,
                      input logic fl, input string tag);
    bit do_s;
    bit do_m;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    do_s = sv && exp_s_ready();
    do_m = mr && (exp_q.size() != 0);
    @(posedge clk);
    if (do_m) begin
      void'(exp_q.pop_front());
      delivered++;
    end
    if (do_s) exp_q.push_back(sd);
    if (fl) exp_q.delete();
    started = 1'b1;
    #1;
    check_model(tag);
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    s_valid   = 1'b1;
    s_data    = 32'hDEAD_BEEF;
    m_ready   = 1'b1;
    started   = 1'b0;
    delivered = 0;

    // ---- Reset: 3 edges with s_valid high ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", W'(s_ready), '0);
    chk("rst_m_valid", W'(m_valid), '0);
    chk("rst_m_data", m_data, '0);
    chk("rst_occ", W'(occupancy), '0);
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    step(1'b0, '0, 1'b1, 1'b0, "rel");
    chk("rel_s_ready_up", W'(s_ready), W'(1));

    // ---- Streaming 1..8 with m_ready high ----
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, W'(i), 1'b1, 1'b0, "stream");
      chk("stream_data", m_data, W'(i));
      chk("stream_occ1", W'(occupancy), W'(1));
    end
    step(1'b0, '0, 1'b1, 1'b0, "stream_drain");

    // ---- Stall and skid ----
    step(1'b1, 32'hA, 1'b0, 1'b0, "stall_a");
    step(1'b1, 32'hB, 1'b0, 1'b0, "stall_b");
    chk("stall_occ2", W'(occupancy), W'(2));
    chk("stall_s_ready0", W'(s_ready), '0);
    step(1'b1, 32'hF, 1'b0, 1'b0, "stall_hold");
    chk("stall_hold_a", m_data, 32'hA);
    step(1'b0, '0, 1'b1, 1'b0, "stall_rel1");
    chk("stall_out_b", m_data, 32'hB);
    chk("stall_s_ready_back", W'(s_ready), W'(1));
    step(1'b0, '0, 1'b1, 1'b0, "stall_rel2");
    chk("stall_empty", W'(m_valid), '0);

    // ---- Simultaneous handshake ----
    step(1'b1, 32'h5, 1'b0, 1'b0, "sim_load");
    step(1'b1, 32'h6, 1'b1, 1'b0, "sim_both");
    chk("sim_data6", m_data, 32'h6);
    chk("sim_occ1", W'(occupancy), W'(1));
    step(1'b0, '0, 1'b1, 1'b0, "sim_drain");

    // ---- Flush in FULL ----
    step(1'b1, 32'hC, 1'b0, 1'b0, "fl_c");
    step(1'b1, 32'hD, 1'b0, 1'b0, "fl_d");
    step(1'b0, '0, 1'b0, 1'b1, "fl_pulse");
    chk("fl_m_valid0", W'(m_valid), '0);
    chk("fl_occ0", W'(occupancy), '0);
    chk("fl_s_ready1", W'(s_ready), W'(1));
    step(1'b1, 32'hE, 1'b0, 1'b0, "fl_e");
    chk("fl_e_out", m_data, 32'hE);
    step(1'b0, '0, 1'b1, 1'b0, "fl_e_take");
    chk("fl_no_trace", W'(m_valid), '0);

    // ---- Flush in BUSY with both handshakes: input word dropped ----
    step(1'b1, 32'h7, 1'b0, 1'b0, "flb_load");
    step(1'b1, 32'h8, 1'b1, 1'b1, "flb_pulse");
    chk("flb_dropped", W'(m_valid), '0);

    // ---- Random soak ----
    for (int c = 0; c < 10000; c++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 99) == 0), "soak");
    end

    // ---- Asynchronous reset mid-operation ----
    step(1'b1, 32'h11, 1'b0, 1'b0, "ar_load");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_m_valid_async", W'(m_valid), '0);
    chk("ar_occ_async", W'(occupancy), '0);
    chk("ar_s_ready_async", W'(s_ready), '0);
    exp_q.delete();
    started = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 32'h22, 1'b1, 1'b0, "ar_rel");
    step(1'b1, 32'h33, 1'b1, 1'b0, "ar_first");
    chk("ar_first_data", m_data, 32'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_kim_skid_buffer
